// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter: scanout reads, buffered CPU writes, clear sweep
module vga_fb_arbiter #(
  parameter int FB_W       = 100,
  parameter int FB_H       = 100,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iWrEnable,
  input  logic [7:0]        iWrCol,
  input  logic [7:0]        iWrRow,
  input  logic [2:0]        iWrColor,
  output logic              oWrBusy,
  input  logic              iRdReq,
  input  logic [7:0]        iRdCol,
  input  logic [7:0]        iRdRow,
  output logic              oRdValid,
  output logic [2:0]        oRdColor,
  input  logic              iClear,
  input  logic [2:0]        iClearColor,
  output logic              oClearBusy,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWe,
  output logic [2:0]        oRamWData,
  input  logic [2:0]        iRamRData,
  output logic [7:0]        oDropCount
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_RUN, ST_CLEAR} state_t;

  function automatic logic in_range(input logic [7:0] col, input logic [7:0] row);
    return (32'(col) < FB_W) && (32'(row) < FB_H);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] col, input logic [7:0] row);
    return ADDR_W'(row) * ADDR_W'(FB_W) + ADDR_W'(col);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_addr_q, clear_addr_d;
  logic [2:0]          clear_color_q, clear_color_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_d [FIFO_DEPTH];
  logic [2:0]          fifo_color_q [FIFO_DEPTH];
  logic [2:0]          fifo_color_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wr_busy_q, wr_busy_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_oob_q, rd_oob_d;
  logic                rd_valid_q, rd_valid_d;
  logic [2:0]          rd_color_q, rd_color_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                rd_hit, wr_ok, push, drop, grant_clear, pop;

  assign oWrBusy    = wr_busy_q;
  assign oRdValid   = rd_valid_q;
  assign oRdColor   = rd_color_q;
  assign oClearBusy = (state_q == ST_CLEAR);
  assign oDropCount = drop_cnt_q;

  // Slot arbitration (read > clear > FIFO), FIFO bookkeeping, FSM next state and read pipeline
  always_comb begin
    rd_hit      = iRdReq && in_range(iRdCol, iRdRow) && !Reset;
    wr_ok       = iWrEnable && !wr_busy_q;
    push        = wr_ok && in_range(iWrCol, iWrRow);
    drop        = wr_ok && !in_range(iWrCol, iWrRow);
    grant_clear = !rd_hit && (state_q == ST_CLEAR) && !Reset;
    pop         = !rd_hit && (state_q == ST_RUN) && (count_q != '0) && !Reset;

    oRamWe    = 1'b0;
    oRamWData = 3'd0;
    oRamAddr  = ram_addr_q;
    if (rd_hit) begin
      oRamAddr = pix_addr(iRdCol, iRdRow);
    end else if (grant_clear) begin
      oRamWe    = 1'b1;
      oRamAddr  = clear_addr_q;
      oRamWData = clear_color_q;
    end else if (pop) begin
      oRamWe    = 1'b1;
      oRamAddr  = fifo_addr_q[rd_ptr_q];
      oRamWData = fifo_color_q[rd_ptr_q];
    end
    ram_addr_d = oRamAddr;

    fifo_addr_d  = fifo_addr_q;
    fifo_color_d = fifo_color_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q]  = pix_addr(iWrCol, iWrRow);
      fifo_color_d[wr_ptr_q] = iWrColor;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    state_d       = state_q;
    clear_addr_d  = clear_addr_q;
    clear_color_d = clear_color_q;
    if (state_q == ST_RUN) begin
      if (iClear) begin
        state_d       = ST_CLEAR;
        clear_addr_d  = '0;
        clear_color_d = iClearColor;
      end
    end else if (grant_clear) begin
      if (clear_addr_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end else begin
        clear_addr_d = clear_addr_q + ADDR_W'(1);
      end
    end

    wr_busy_d = (count_d == FULL_CNT) || (state_d == ST_CLEAR);

    // Out-of-range reads ride the same two-stage pipe but return zero
    rd_pend_d  = iRdReq;
    rd_oob_d   = !in_range(iRdCol, iRdRow);
    rd_valid_d = rd_pend_q;
    rd_color_d = rd_oob_q ? 3'd0 : iRamRData;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_RUN;
      clear_addr_q  <= '0;
      clear_color_q <= 3'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wr_busy_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_oob_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_color_q    <= 3'd0;
      drop_cnt_q    <= 8'd0;
      ram_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      clear_addr_q  <= clear_addr_d;
      clear_color_q <= clear_color_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wr_busy_q     <= wr_busy_d;
      rd_pend_q     <= rd_pend_d;
      rd_oob_q      <= rd_oob_d;
      rd_valid_q    <= rd_valid_d;
      rd_color_q    <= rd_color_d;
      drop_cnt_q    <= drop_cnt_d;
      ram_addr_q    <= ram_addr_d;
    end
  end

  // FIFO storage needs no reset; pointers and count define which entries are live
  always_ff @(posedge Clock) begin
    fifo_addr_q  <= fifo_addr_d;
    fifo_color_q <= fifo_color_d;
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed and randomized model-checked bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
  localparam int FB_W = 100;
  localparam int FB_H = 100;
  localparam int ADDR_W = 14;
  localparam int FIFO_DEPTH = 4;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              iWrEnable = 1'b0;
  logic [7:0]        iWrCol = 8'd0;
  logic [7:0]        iWrRow = 8'd0;
  logic [2:0]        iWrColor = 3'd0;
  logic              oWrBusy;
  logic              iRdReq = 1'b0;
  logic [7:0]        iRdCol = 8'd0;
  logic [7:0]        iRdRow = 8'd0;
  logic              oRdValid;
  logic [2:0]        oRdColor;
  logic              iClear = 1'b0;
  logic [2:0]        iClearColor = 3'd0;
  logic              oClearBusy;
  logic [ADDR_W-1:0] oRamAddr;
  logic              oRamWe;
  logic [2:0]        oRamWData;
  logic [2:0]        iRamRData;
  logic [7:0]        oDropCount;

  vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .iWrEnable(iWrEnable), .iWrCol(iWrCol), .iWrRow(iWrRow), .iWrColor(iWrColor), .oWrBusy(oWrBusy),
    .iRdReq(iRdReq), .iRdCol(iRdCol), .iRdRow(iRdRow), .oRdValid(oRdValid), .oRdColor(oRdColor),
    .iClear(iClear), .iClearColor(iClearColor), .oClearBusy(oClearBusy),
    .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamWData(oRamWData), .iRamRData(iRamRData),
    .oDropCount(oDropCount)
  );

  always #5 Clock = ~Clock;

  logic [2:0] mem [1 << ADDR_W];
  int cyc = 0;

  // Single-port RAM with one-cycle read latency
  always @(posedge Clock) begin
    if (oRamWe) mem[oRamAddr] <= oRamWData;
    iRamRData <= mem[oRamAddr];
    cyc <= cyc + 1;
  end

  typedef struct { int c; int a; int d; } wr_t;
  typedef struct { int c; logic [2:0] v; } rd_t;
  wr_t wr_log[$];
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  int clear_busy_cnt = 0;
  int collisions = 0;

  // Record every RAM write and any write that shares a cycle with an in-range read
  always @(negedge Clock) begin
    if (oRamWe) wr_log.push_back('{cyc, int'(oRamAddr), int'(oRamWData)});
    if (oClearBusy) clear_busy_cnt++;
    if (oRamWe && iRdReq && int'(iRdCol) < FB_W && int'(iRdRow) < FB_H) collisions++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic mid();
    @(negedge Clock);
    #1;
  endtask

  task automatic check_rd_out();
    if (exp_rd.size() > 0 && exp_rd[0].c == cyc) begin
      check("rd_valid", 32'(oRdValid), 32'd1);
      check("rd_color", 32'(oRdColor), 32'(exp_rd[0].v));
      void'(exp_rd.pop_front());
    end else begin
      check("rd_idle", 32'(oRdValid), 32'd0);
    end
  endtask

  int t0, pushed, drops, bad, a, nmin;
  logic exp_busy;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 3'd0;
    mem[9999] <= 3'b100;
    mem[100]  <= 3'b111;

    // Reset state
    repeat (3) nxt();
    mid();
    check("rst_wr_busy", 32'(oWrBusy), 32'd0);
    check("rst_rd_valid", 32'(oRdValid), 32'd0);
    check("rst_rd_color", 32'(oRdColor), 32'd0);
    check("rst_clear_busy", 32'(oClearBusy), 32'd0);
    check("rst_ram_we", 32'(oRamWe), 32'd0);
    check("rst_ram_addr", 32'(oRamAddr), 32'd0);
    check("rst_ram_wdata", 32'(oRamWData), 32'd0);
    check("rst_drop", 32'(oDropCount), 32'd0);
    nxt();
    Reset = 1'b0;
    wr_log.delete();

    // Single write drains within two cycles
    nxt();
    iWrEnable = 1'b1; iWrCol = 8'd5; iWrRow = 8'd2; iWrColor = 3'b010;
    t0 = cyc;
    mid();
    check("t1_busy0", 32'(oWrBusy), 32'd0);
    nxt();
    iWrEnable = 1'b0;
    mid();
    check("t1_busy1", 32'(oWrBusy), 32'd0);
    nxt(); nxt(); mid();
    check("t1_nwr", wr_log.size(), 32'd1);
    if (wr_log.size() >= 1) begin
      check("t1_addr", wr_log[0].a, 2 * FB_W + 5);
      check("t1_data", wr_log[0].d, 32'd2);
      check("t1_lat", 32'(wr_log[0].c - t0 >= 1 && wr_log[0].c - t0 <= 2), 32'd1);
    end
    wr_log.delete();

    // Reads hold off writes; FIFO fills, then drains in order
    nxt();
    iRdReq = 1'b1; iRdCol = 8'd0; iRdRow = 8'd0;
    for (int k = 0; k < 4; k++) begin
      iWrEnable = 1'b1; iWrCol = 8'(10 + k); iWrRow = 8'd20; iWrColor = 3'(k + 1);
      mid();
      check("t2_busy_fill", 32'(oWrBusy), 32'd0);
      nxt();
    end
    iWrCol = 8'd50; iWrRow = 8'd50; iWrColor = 3'd7;
    mid();
    check("t2_busy_full", 32'(oWrBusy), 32'd1);
    nxt();
    iWrCol = 8'd200; iWrRow = 8'd0;
    mid();
    check("t2_busy_full2", 32'(oWrBusy), 32'd1);
    nxt();
    iWrEnable = 1'b0;
    mid();
    check("t2_no_drop", 32'(oDropCount), 32'd0);
    check("t2_no_wr", wr_log.size(), 32'd0);
    nxt();
    iRdReq = 1'b0;
    t0 = cyc;
    repeat (5) begin mid(); nxt(); end
    mid();
    check("t2_nwr", wr_log.size(), 32'd4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
      check("t2_addr", wr_log[k].a, 20 * FB_W + 10 + k);
      check("t2_data", wr_log[k].d, k + 1);
      check("t2_cyc", wr_log[k].c, t0 + k);
    end
    check("t2_busy_clr", 32'(oWrBusy), 32'd0);
    wr_log.delete();

    // Read latency, in range and out of range
    nxt();
    iRdReq = 1'b1; iRdCol = 8'd99; iRdRow = 8'd99;
    mid();
    check("t3_addr", 32'(oRamAddr), 32'd9999);
    check("t3_we", 32'(oRamWe), 32'd0);
    nxt();
    iRdReq = 1'b0;
    mid();
    check("t3_n1_valid", 32'(oRdValid), 32'd0);
    nxt(); mid();
    check("t3_n2_valid", 32'(oRdValid), 32'd1);
    check("t3_n2_color", 32'(oRdColor), 32'b100);
    nxt();
    iRdReq = 1'b1; iRdCol = 8'd100; iRdRow = 8'd0;
    mid();
    check("t3_oob_we", 32'(oRamWe), 32'd0);
    check("t3_oob_addr_hold", 32'(oRamAddr), 32'd9999);
    nxt();
    iRdReq = 1'b0;
    mid();
    check("t3_oob_n1", 32'(oRdValid), 32'd0);
    nxt(); mid();
    check("t3_oob_valid", 32'(oRdValid), 32'd1);
    check("t3_oob_color", 32'(oRdColor), 32'd0);

    // Randomized traffic against a FIFO-order / fixed-latency reference
    wr_log.delete();
    pushed = 0; drops = 0;
    for (int i = 0; i < 420; i++) begin
      nxt();
      exp_busy = ((pushed - int'(wr_log.size())) == FIFO_DEPTH);
      check("rand_busy", 32'(oWrBusy), 32'(exp_busy));
      iWrEnable = 1'b0; iRdReq = 1'b0;
      if (i < 400) begin
        iWrEnable = ($urandom_range(0, 1) == 1);
        iWrCol = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99));
        iWrRow = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99));
        iWrColor = 3'($urandom);
        iRdReq = ($urandom_range(0, 9) < ((i < 200) ? 8 : 3));
        iRdCol = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99));
        iRdRow = 8'($urandom_range(0, 99));
      end
      if (iWrEnable && !exp_busy) begin
        if (int'(iWrCol) < FB_W && int'(iWrRow) < FB_H) begin
          exp_wr.push_back('{0, int'(iWrRow) * FB_W + int'(iWrCol), int'(iWrColor)});
          pushed++;
        end else begin
          drops++;
        end
      end
      mid();
      if (iRdReq) begin
        if (int'(iRdCol) < FB_W && int'(iRdRow) < FB_H) begin
          a = int'(iRdRow) * FB_W + int'(iRdCol);
          check("rand_rd_addr", 32'(oRamAddr), 32'(a));
          check("rand_rd_we", 32'(oRamWe), 32'd0);
          exp_rd.push_back('{cyc + 2, mem[a]});
        end else begin
          exp_rd.push_back('{cyc + 2, 3'd0});
        end
      end
      check_rd_out();
    end
    check("rand_nwr", wr_log.size(), exp_wr.size());
    nmin = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int j = 0; j < nmin; j++) begin
      check("rand_wr_addr", wr_log[j].a, exp_wr[j].a);
      check("rand_wr_data", wr_log[j].d, exp_wr[j].d);
    end
    check("rand_drop", 32'(oDropCount), (drops > 255) ? 255 : drops);
    check("rand_collision", collisions, 32'd0);
    check("rand_rd_pending", exp_rd.size(), 32'd0);

    // Reset discards a read in flight
    nxt();
    iRdReq = 1'b1; iRdCol = 8'd1; iRdRow = 8'd1;
    nxt();
    iRdReq = 1'b0; Reset = 1'b1;
    nxt();
    Reset = 1'b0;
    mid();
    check("rst_rd_discard", 32'(oRdValid), 32'd0);
    check("rst_drop_clr", 32'(oDropCount), 32'd0);
    nxt(); mid();
    check("rst_rd_discard2", 32'(oRdValid), 32'd0);

    // Out-of-range writes are dropped and counted, saturating
    wr_log.delete();
    for (int k = 0; k < 3; k++) begin
      nxt();
      iWrEnable = 1'b1; iWrCol = 8'd120; iWrRow = 8'd3; iWrColor = 3'd5;
    end
    nxt();
    iWrEnable = 1'b0;
    mid();
    check("t4_drop3", 32'(oDropCount), 32'd3);
    nxt(); nxt(); mid();
    check("t4_no_wr", wr_log.size(), 32'd0);
    for (int k = 0; k < 300; k++) begin
      nxt();
      iWrEnable = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        iWrCol = 8'($urandom_range(100, 255)); iWrRow = 8'($urandom_range(0, 255));
      end else begin
        iWrCol = 8'($urandom_range(0, 255)); iWrRow = 8'($urandom_range(100, 255));
      end
      mid();
      check("t4_drop_run", 32'(oDropCount), (3 + k > 255) ? 255 : 3 + k);
    end
    nxt();
    iWrEnable = 1'b0;
    mid();
    check("t4_drop_sat", 32'(oDropCount), 32'd255);
    check("t4_no_wr2", wr_log.size(), 32'd0);

    // Full clear sweep; queued writes land afterwards; iClear mid-sweep ignored
    wr_log.delete();
    nxt();
    iRdReq = 1'b1; iRdCol = 8'd0; iRdRow = 8'd0;
    iWrEnable = 1'b1; iWrCol = 8'd7; iWrRow = 8'd7; iWrColor = 3'd5;
    nxt();
    iWrCol = 8'd8; iWrRow = 8'd8; iWrColor = 3'd6;
    nxt();
    iWrEnable = 1'b0; iClear = 1'b1; iClearColor = 3'b001;
    nxt();
    iClear = 1'b0; iRdReq = 1'b0;
    clear_busy_cnt = 0;
    t0 = cyc;
    for (int j = 0; j < 10010; j++) begin
      iClear = (j == 5000);
      iClearColor = (j == 5000) ? 3'b111 : 3'b001;
      if (j == 10) begin
        mid();
        check("t5_wr_busy", 32'(oWrBusy), 32'd1);
        check("t5_clear_busy", 32'(oClearBusy), 32'd1);
      end
      nxt();
    end
    iClear = 1'b0;
    mid();
    check("t5_nwr", wr_log.size(), 32'd10002);
    bad = 0;
    for (int j = 0; j < 10000 && j < wr_log.size(); j++) begin
      if (wr_log[j].a != j || wr_log[j].d != 1 || wr_log[j].c != t0 + j) bad++;
    end
    check("t5_sweep_bad", bad, 32'd0);
    if (wr_log.size() >= 10002) begin
      check("t5_q0_addr", wr_log[10000].a, 7 * FB_W + 7);
      check("t5_q0_data", wr_log[10000].d, 32'd5);
      check("t5_q1_addr", wr_log[10001].a, 8 * FB_W + 8);
      check("t5_q1_data", wr_log[10001].d, 32'd6);
    end
    check("t5_busy_cycles", clear_busy_cnt, 32'd10000);
    check("t5_clear_done", 32'(oClearBusy), 32'd0);
    check("t5_wr_busy_done", 32'(oWrBusy), 32'd0);

    // Reset mid-sweep aborts the sweep and empties the FIFO
    wr_log.delete();
    nxt();
    iRdReq = 1'b1; iRdCol = 8'd0; iRdRow = 8'd0;
    iWrEnable = 1'b1; iWrCol = 8'd9; iWrRow = 8'd9; iWrColor = 3'd3;
    nxt();
    iWrEnable = 1'b0; iClear = 1'b1; iClearColor = 3'b110;
    nxt();
    iClear = 1'b0; iRdReq = 1'b0;
    repeat (500) nxt();
    mid();
    check("t6_addr500", 32'(oRamAddr), 32'd500);
    check("t6_we500", 32'(oRamWe), 32'd1);
    check("t6_data500", 32'(oRamWData), 32'b110);
    nxt();
    Reset = 1'b1;
    mid();
    check("t6_we_reset", 32'(oRamWe), 32'd0);
    nxt();
    Reset = 1'b0;
    mid();
    check("t6_clear_busy", 32'(oClearBusy), 32'd0);
    check("t6_drop", 32'(oDropCount), 32'd0);
    check("t6_wr_busy", 32'(oWrBusy), 32'd0);
    check("t6_we_after", 32'(oRamWe), 32'd0);
    repeat (5) nxt();
    mid();
    check("t6_nwr", wr_log.size(), 32'd501);
    if (wr_log.size() > 0) check("t6_last_addr", wr_log[wr_log.size() - 1].a, 32'd500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
